ram_capture_fsm: RTL and testbench
==================================

RAM_CAPTURE_FSM -- requirements
Module: ram_capture_fsm

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 13, meaning sample width; it matches the FIR output width.
REQ-002 The block SHALL have parameter NB_ADDR, default 10, meaning capture-RAM address width, so DEPTH = 2^NB_ADDR.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_valid, input, 1 bit: sample strobe, one cycle wide, shared with the FIR stage.
REQ-006 The block SHALL have port i_data, input, NB_DATA bits: FIR output sample, qualified by i_valid.
REQ-007 The block SHALL have port i_enable, input, 1 bit: capture gate; while low, i_valid is ignored.
REQ-008 The block SHALL have port i_start, input, 1 bit: arms a capture; level-sampled each cycle.
REQ-009 The block SHALL have port i_clear, input, 1 bit: returns the block from DONE to IDLE.
REQ-010 The block SHALL have port i_rd_addr, input, NB_ADDR bits: readout address.
REQ-011 The block SHALL have port o_rd_data, output, NB_DATA bits: registered RAM word read from i_rd_addr.
REQ-012 The block SHALL have port o_rd_valid, output, 1 bit: high when o_rd_data was read while in DONE.
REQ-013 The block SHALL have port o_busy, output, 1 bit: high in CAPTURE.
REQ-014 The block SHALL have port o_done, output, 1 bit: high in DONE.
REQ-015 The block SHALL have port o_wr_count, output, NB_ADDR+1 bits: samples written in the current capture.

Function
REQ-016 The FSM SHALL have three states: IDLE, CAPTURE, DONE.
REQ-017 IDLE SHALL move to CAPTURE on the first cycle with i_start=1 and i_clear=0; that transition SHALL zero the write pointer and o_wr_count.
REQ-018 In CAPTURE, each cycle with i_valid=1 and i_enable=1 SHALL write i_data to ram[wr_ptr], increment wr_ptr (mod DEPTH) and increment o_wr_count; a write is accepted on the same cycle the state becomes CAPTURE only if the strobe arrives after the transition edge.
REQ-019 The write that makes o_wr_count equal DEPTH SHALL move the FSM to DONE on the same edge; no further writes SHALL occur; wr_ptr wraps to 0 without side effects.
REQ-020 i_start SHALL be ignored in CAPTURE and in DONE.
REQ-021 DONE SHALL move to IDLE on i_clear=1; in CAPTURE, i_clear=1 SHALL abort to IDLE with o_wr_count held; i_clear SHALL take priority over i_start in every state.
REQ-022 o_rd_data SHALL equal ram[i_rd_addr] sampled one cycle earlier (1-cycle latency) in every state; o_rd_valid SHALL be the registered value of (state==DONE).
REQ-023 A read and a write to the same address in one cycle SHALL return the old contents.
REQ-024 o_busy and o_done SHALL be decoded directly from the registered state, with no extra latency.
REQ-025 i_valid pulses while i_enable=0, or outside CAPTURE, SHALL have no effect.

Reset
REQ-026 While i_reset=0, the block SHALL asynchronously force: state=IDLE, wr_ptr=0, o_wr_count=0, o_rd_data=0, o_rd_valid=0, o_busy=0, o_done=0.
REQ-027 RAM contents SHALL NOT be reset, and SHALL be undefined after a reset that occurs mid-capture.
REQ-028 Reset deassertion SHALL be synchronised by the integrator; the block SHALL resume from IDLE on the first edge after release.

Structure
REQ-029 The state encodings (IDLE=2'b00, CAPTURE=2'b01, DONE=2'b10) and the default NB_DATA/NB_ADDR values SHALL live in the shared project header/package.
REQ-030 The storage SHALL be one sub-module, ram_dp: a simple dual-port RAM with one synchronous write port, one registered read port, and read-old-on-collision behaviour.
REQ-031 The FSM, pointer and counter SHALL stay in ram_capture_fsm.

Verification (bench uses NB_ADDR=3, DEPTH=8)
REQ-032 Reset, then i_start pulse, then 8 i_valid strobes with data 1..8 (i_enable=1) -> o_busy goes high, then o_done=1 on the 8th write edge, o_wr_count=8, and reading addresses 0..7 returns 1..7,8 one cycle later with o_rd_valid=1.
REQ-033 In CAPTURE, 3 strobes with i_enable=0 interleaved between 8 enabled strobes -> exactly 8 writes, and the ignored data never appears in RAM.
REQ-034 In DONE, extra i_valid and i_start -> RAM unchanged and state stays DONE; then i_clear -> IDLE with o_done=0.
REQ-035 i_reset pulsed low after 4 captured samples -> all outputs 0 immediately (asynchronously), state IDLE, and a new capture restarts at address 0.
REQ-036 i_start and i_clear high together in IDLE -> stays IDLE; i_clear after 5 samples in CAPTURE -> IDLE with o_wr_count=5.
REQ-037 i_rd_addr equal to wr_ptr on a write cycle -> o_rd_data shows the old word, and the new word appears on the next read.

Source files
------------

// File: rtl/ram_capture_fsm_pkg.sv
// Shared definitions for the capture block: default sizes and FSM state encoding.
package ram_capture_fsm_pkg;

  localparam int unsigned NbDataDefault = 13;
  localparam int unsigned NbAddrDefault = 10;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StCapture = 2'b01,
    StDone    = 2'b10
  } state_e;

endpackage

// File: rtl/ram_capture_fsm_ram_dp.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module ram_dp #(
  parameter int unsigned NB_DATA = 13,
  parameter int unsigned NB_ADDR = 10
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_wr_en,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);

  localparam int unsigned Depth = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] mem_q [Depth];
  logic [NB_DATA-1:0] rd_data_q;

  // Storage array; deliberately not reset.
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read; samples the pre-write contents on a collision.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[i_rd_addr];
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/ram_capture_fsm.sv
// Capture FSM: arms on i_start, stores DEPTH enabled samples into a RAM, then
// holds in DONE for readout until i_clear.
module ram_capture_fsm
  import ram_capture_fsm_pkg::*;
#(
  parameter int unsigned NB_DATA = NbDataDefault,
  parameter int unsigned NB_ADDR = NbAddrDefault
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_enable,
  input  logic               i_start,
  input  logic               i_clear,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_ADDR:0]   o_wr_count
);

  // Count value meaning the RAM is full (DEPTH).
  localparam logic [NB_ADDR:0] FullCount = {1'b1, {NB_ADDR{1'b0}}};

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [NB_ADDR:0]   wr_count_q, wr_count_d;
  logic               rd_valid_q;
  logic               wr_en;

  // Next-state, pointer/counter update and write strobe.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_count_d = wr_count_q;
    wr_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!i_clear && i_start) begin
          state_d    = StCapture;
          wr_ptr_d   = '0;
          wr_count_d = '0;
        end
      end
      StCapture: begin
        if (i_clear) begin
          // Abort keeps the count so software can see how far it got.
          state_d = StIdle;
        end else if (i_valid && i_enable) begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          wr_count_d = wr_count_q + 1'b1;
          if (wr_count_q == FullCount - 1'b1) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (i_clear) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pointer, counter and read-valid registers.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      wr_count_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_count_q <= wr_count_d;
      rd_valid_q <= (state_q == StDone);
    end
  end

  ram_dp #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_ram (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (i_data),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );

  assign o_busy     = (state_q == StCapture);
  assign o_done     = (state_q == StDone);
  assign o_rd_valid = rd_valid_q;
  assign o_wr_count = wr_count_q;

endmodule

// File: tb/tb_ram_capture_fsm.sv
// Bench for ram_capture_fsm with an 8-deep RAM: directed scenarios followed by
// random traffic, all checked every cycle against a behavioural model.
module tb_ram_capture_fsm;

  localparam int NbData = 13;
  localparam int NbAddr = 3;
  localparam int Depth  = 8;

  localparam int MIdle = 0;
  localparam int MCap  = 1;
  localparam int MDone = 2;

  logic              clock = 1'b0;
  logic              i_reset;
  logic              i_valid;
  logic [NbData-1:0] i_data;
  logic              i_enable;
  logic              i_start;
  logic              i_clear;
  logic [NbAddr-1:0] i_rd_addr;
  logic [NbData-1:0] o_rd_data;
  logic              o_rd_valid;
  logic              o_busy;
  logic              o_done;
  logic [NbAddr:0]   o_wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model.
  int m_phase;
  int m_ptr;
  int m_cnt;
  int m_mem [Depth];
  bit m_known [Depth];
  int m_rd_data;
  bit m_rd_known;
  bit m_rd_valid;

  always #5 clock = ~clock;

  ram_capture_fsm #(
    .NB_DATA (NbData),
    .NB_ADDR (NbAddr)
  ) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_enable   (i_enable),
    .i_start    (i_start),
    .i_clear    (i_clear),
    .i_rd_addr  (i_rd_addr),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_wr_count (o_wr_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase    = MIdle;
    m_ptr      = 0;
    m_cnt      = 0;
    m_rd_data  = 0;
    m_rd_known = 1'b1;
    m_rd_valid = 1'b0;
    for (int i = 0; i < Depth; i++) m_known[i] = 1'b0;
  endtask

  // Apply the behaviour of one rising edge using the inputs held across it.
  task automatic model_edge();
    if (!i_reset) begin
      model_reset();
      return;
    end
    m_rd_data  = m_mem[int'(i_rd_addr)];
    m_rd_known = m_known[int'(i_rd_addr)];
    m_rd_valid = (m_phase == MDone);
    if (m_phase == MIdle) begin
      if (i_start && !i_clear) begin
        m_phase = MCap;
        m_ptr   = 0;
        m_cnt   = 0;
      end
    end else if (m_phase == MCap) begin
      if (i_clear) begin
        m_phase = MIdle;
      end else if (i_valid && i_enable) begin
        m_mem[m_ptr]   = int'(i_data);
        m_known[m_ptr] = 1'b1;
        m_ptr          = (m_ptr + 1) % Depth;
        m_cnt          = m_cnt + 1;
        if (m_cnt == Depth) m_phase = MDone;
      end
    end else begin
      if (i_clear) m_phase = MIdle;
    end
  endtask

  task automatic check_outputs();
    check_eq("busy", 32'(o_busy), 32'(m_phase == MCap));
    check_eq("done", 32'(o_done), 32'(m_phase == MDone));
    check_eq("wr_count", 32'(o_wr_count), 32'(m_cnt));
    check_eq("rd_valid", 32'(o_rd_valid), 32'(m_rd_valid));
    if (m_rd_known) check_eq("rd_data", 32'(o_rd_data), 32'(m_rd_data));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    i_valid  = 1'b0;
    i_enable = 1'b0;
    i_start  = 1'b0;
    i_clear  = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
  endtask

  task automatic strobe(input int data, input bit en);
    i_valid  = 1'b1;
    i_enable = en;
    i_data   = NbData'(data);
    step();
    i_valid  = 1'b0;
    i_enable = 1'b0;
  endtask

  task automatic readout();
    for (int a = 0; a < Depth; a++) begin
      i_rd_addr = NbAddr'(a);
      step();
    end
  endtask

  // Hard stop if something wedges the run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < Depth; i++) m_mem[i] = 0;
    model_reset();
    idle_inputs();
    i_data    = '0;
    i_rd_addr = '0;
    i_reset   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_outputs();
    i_reset = 1'b1;
    step();

    // Basic capture of 1..8 with gaps, then readout.
    pulse_start();
    for (int k = 1; k <= Depth; k++) begin
      strobe(k, 1'b1);
      step();
    end
    check_eq("full_count", 32'(o_wr_count), 32'(Depth));
    readout();
    step();

    // DONE ignores strobes and start; readout unchanged; clear returns to idle.
    i_valid  = 1'b1;
    i_enable = 1'b1;
    i_data   = 13'h1fff;
    i_start  = 1'b1;
    repeat (2) step();
    idle_inputs();
    readout();
    pulse_clear();
    check_eq("done_after_clear", 32'(o_done), 32'd0);

    // Disabled strobes interleaved with enabled ones.
    pulse_start();
    for (int k = 0; k < Depth; k++) begin
      strobe(32'h40 + k, 1'b1);
      if (k == 1 || k == 4 || k == 6) strobe(32'h1abc, 1'b0);
    end
    readout();
    pulse_clear();

    // Read address tracking the write pointer exposes old-word-on-collision.
    pulse_start();
    for (int k = 0; k < Depth; k++) begin
      i_rd_addr = NbAddr'(m_ptr);
      strobe(32'h100 + k, 1'b1);
      step();
    end
    readout();

    // Start and clear together from idle stays idle; abort keeps the count.
    pulse_clear();
    i_start = 1'b1;
    i_clear = 1'b1;
    step();
    idle_inputs();
    check_eq("start_clear_idle", 32'(o_busy), 32'd0);
    pulse_start();
    for (int k = 0; k < 5; k++) strobe(32'h200 + k, 1'b1);
    pulse_clear();
    check_eq("abort_count", 32'(o_wr_count), 32'd5);

    // Asynchronous reset mid-capture, then a fresh capture from address 0.
    pulse_start();
    for (int k = 0; k < 4; k++) strobe(32'h300 + k, 1'b1);
    i_reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_eq("async_rd_data", 32'(o_rd_data), 32'd0);
    step();
    i_reset = 1'b1;
    step();
    pulse_start();
    for (int k = 0; k < Depth; k++) strobe(32'h400 + k, 1'b1);
    readout();
    pulse_clear();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      i_start   = ($urandom_range(0, 7) == 0);
      i_clear   = ($urandom_range(0, 39) == 0);
      i_valid   = $urandom_range(0, 1) == 1;
      i_enable  = ($urandom_range(0, 3) != 0);
      i_data    = NbData'($urandom);
      i_rd_addr = NbAddr'($urandom);
      step();
    end
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
